// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Round-robin arbiter that lets NUM_CONSUMERS channels share one memory port.
//   Only one transaction is outstanding to memory at a time. When a consumer
//   has both a read and a write pending, the read is served first. After a
//   transaction, the round-robin pointer moves to the consumer after the one
//   just served. When the memory responds, the consumer's ready output stays
//   high until that consumer drops the matching valid.
//
// Ports
//   clk, reset                  single clock; asynchronous active-high reset
//   consumer_read_valid/_address   per-consumer read requests (packed)
//   consumer_read_ready/_data      per-consumer read completion and data (packed)
//   consumer_write_valid/_address/_data  per-consumer write requests (packed)
//   consumer_write_ready           per-consumer write completion
//   mem_read_valid/_address, mem_read_ready/_data     memory read channel
//   mem_write_valid/_address/_data, mem_write_ready   memory write channel
//   busy                        high whenever the arbiter is not idle
//   grant_id                    index of the consumer currently being served
module mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
    output logic                                 mem_read_valid,
    output logic [ADDR_BITS-1:0]                 mem_read_address,
    input  logic                                 mem_read_ready,
    input  logic [DATA_BITS-1:0]                 mem_read_data,
    output logic                                 mem_write_valid,
    output logic [ADDR_BITS-1:0]                 mem_write_address,
    output logic [DATA_BITS-1:0]                 mem_write_data,
    input  logic                                 mem_write_ready,
    output logic                                 busy,
    output logic [$clog2(NUM_CONSUMERS)-1:0]     grant_id
);

    localparam int GW = $clog2(NUM_CONSUMERS);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ_WAIT  = 2'd1;
    localparam logic [1:0] WRITE_WAIT = 2'd2;
    localparam logic [1:0] RELAY      = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [GW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]              grant_q, grant_d;
    logic                       mem_rv_q, mem_rv_d;
    logic                       mem_wv_q, mem_wv_d;
    logic [ADDR_BITS-1:0]       mem_ra_q, mem_ra_d;
    logic [ADDR_BITS-1:0]       mem_wa_q, mem_wa_d;
    logic [DATA_BITS-1:0]       mem_wd_q, mem_wd_d;
    logic                       relay_wr_q, relay_wr_d;
    logic [NUM_CONSUMERS-1:0]   rd_rdy_q, rd_rdy_d;
    logic [NUM_CONSUMERS-1:0]   wr_rdy_q, wr_rdy_d;
    logic [DATA_BITS-1:0]       rd_data_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]       rd_data_d [NUM_CONSUMERS];

    // Unpacked views of the packed consumer buses.
    logic [ADDR_BITS-1:0]       rd_addr_a [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]       wr_addr_a [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]       wr_data_a [NUM_CONSUMERS];

    // With the write path disabled, write requests are invisible to the scan.
    logic [NUM_CONSUMERS-1:0]   wr_valid_eff;

    logic                       sel_found;
    logic                       sel_read;
    logic [GW-1:0]              sel_idx;
    logic                       g_rv;
    logic                       g_wv;

    for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_unpack
        assign rd_addr_a[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
        assign wr_addr_a[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
        assign wr_data_a[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
    end

    assign wr_valid_eff = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

    assign g_rv = consumer_read_valid[grant_q];
    assign g_wv = wr_valid_eff[grant_q];

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] p);
        int t;
        t = int'(p) + 1;
        if (t >= NUM_CONSUMERS) begin
            t = 0;
        end
        return GW'(t);
    endfunction

    // Round-robin scan: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int cand;
        logic [GW-1:0] cidx;
        sel_found = 1'b0;
        sel_read  = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cidx      = '0;
        for (int off = 0; off < NUM_CONSUMERS; off++) begin
            cand = int'(rr_ptr_q) + off;
            if (cand >= NUM_CONSUMERS) begin
                cand = cand - NUM_CONSUMERS;
            end
            cidx = GW'(cand);
            if (!sel_found && (consumer_read_valid[cidx] || wr_valid_eff[cidx])) begin
                sel_found = 1'b1;
                sel_idx   = cidx;
                // A read wins over a write from the same consumer.
                sel_read  = consumer_read_valid[cidx];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        mem_rv_d   = mem_rv_q;
        mem_wv_d   = mem_wv_q;
        mem_ra_d   = mem_ra_q;
        mem_wa_d   = mem_wa_q;
        mem_wd_d   = mem_wd_q;
        relay_wr_d = relay_wr_q;
        rd_rdy_d   = rd_rdy_q;
        wr_rdy_d   = wr_rdy_q;
        rd_data_d  = rd_data_q;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    if (sel_read) begin
                        mem_rv_d = 1'b1;
                        mem_ra_d = rd_addr_a[sel_idx];
                        state_d  = READ_WAIT;
                    end else begin
                        mem_wv_d = 1'b1;
                        mem_wa_d = wr_addr_a[sel_idx];
                        mem_wd_d = wr_data_a[sel_idx];
                        state_d  = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_rv_d           = 1'b0;
                    rd_data_d[grant_q] = mem_read_data;
                    if (g_rv) begin
                        rd_rdy_d[grant_q] = 1'b1;
                        relay_wr_d        = 1'b0;
                        state_d           = RELAY;
                    end else begin
                        // Consumer gave up while waiting: no ready pulse.
                        rr_ptr_d = next_ptr(grant_q);
                        state_d  = IDLE;
                    end
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_wv_d = 1'b0;
                    if (g_wv) begin
                        wr_rdy_d[grant_q] = 1'b1;
                        relay_wr_d        = 1'b1;
                        state_d           = RELAY;
                    end else begin
                        rr_ptr_d = next_ptr(grant_q);
                        state_d  = IDLE;
                    end
                end
            end
            RELAY: begin
                if (relay_wr_q ? !g_wv : !g_rv) begin
                    rd_rdy_d = '0;
                    wr_rdy_d = '0;
                    rr_ptr_d = next_ptr(grant_q);
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            mem_rv_q   <= 1'b0;
            mem_wv_q   <= 1'b0;
            mem_ra_q   <= '0;
            mem_wa_q   <= '0;
            mem_wd_q   <= '0;
            relay_wr_q <= 1'b0;
            rd_rdy_q   <= '0;
            wr_rdy_q   <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            mem_rv_q   <= mem_rv_d;
            mem_wv_q   <= mem_wv_d;
            mem_ra_q   <= mem_ra_d;
            mem_wa_q   <= mem_wa_d;
            mem_wd_q   <= mem_wd_d;
            relay_wr_q <= relay_wr_d;
            rd_rdy_q   <= rd_rdy_d;
            wr_rdy_q   <= wr_rdy_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign busy                 = (state_q != IDLE);
    assign grant_id             = grant_q;
    assign mem_read_valid       = mem_rv_q;
    assign mem_read_address     = mem_ra_q;
    assign consumer_read_ready  = rd_rdy_q;
    assign mem_write_valid      = (WRITE_ENABLE != 0) && mem_wv_q;
    assign mem_write_address    = mem_wa_q;
    assign mem_write_data       = mem_wd_q;
    assign consumer_write_ready = (WRITE_ENABLE != 0) ? wr_rdy_q : '0;

endmodule
